// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline fill counter plus stall/bubble/flush sequencing; HAZARD_PERF_CNT_EN adds perf counters
module hazard_control_unit #(
   parameter logic [2:0] FILL_DEPTH   = 3'd4,
   parameter int         FLUSH_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       idex_memread,
   input  logic [4:0] idex_rd,
   input  logic [4:0] ifid_rs1,
   input  logic [4:0] ifid_rs2,
   input  logic       ifid_uses_rs2,
   input  logic       mispredict,
   input  logic       mem_wait,
   output logic       pc_write,
   output logic       ifid_write,
   output logic       ifid_flush,
   output logic       idex_bubble,
   output logic [2:0] pcsrc_counter,
   output logic       busy
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] stall_count,
   output logic [31:0] flush_count
`endif
);
   typedef enum logic [1:0] {RUN, FLUSH, HOLD} state_t;
   state_t     state, state_nxt;
   logic [2:0] flush_cnt, flush_cnt_nxt, cnt_nxt;
   logic       lu_stalled, load_use, stall_now, flush_take;
   assign load_use = idex_memread & (idex_rd != 5'd0) &
                     ((idex_rd == ifid_rs1) | (ifid_uses_rs2 & (idex_rd == ifid_rs2)));
   assign busy = (state != RUN);
   // next state, counters and pipeline enables; priority mem_wait > mispredict > load_use
   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      cnt_nxt       = pcsrc_counter;
      pc_write      = 1'b1;
      ifid_write    = 1'b1;
      ifid_flush    = 1'b0;
      idex_bubble   = 1'b0;
      stall_now     = 1'b0;
      flush_take    = 1'b0;
      case (state)
         RUN: begin
            if (mem_wait) begin
               state_nxt  = HOLD;
               pc_write   = 1'b0;
               ifid_write = 1'b0;
            end else if (mispredict) begin
               state_nxt     = FLUSH;
               flush_take    = 1'b1;
               ifid_flush    = 1'b1;
               idex_bubble   = 1'b1;
               flush_cnt_nxt = 3'(FLUSH_CYCLES - 1);
               cnt_nxt       = 3'd0;
            end else if (load_use && !lu_stalled) begin
               stall_now   = 1'b1;
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
            end else begin
               cnt_nxt = (pcsrc_counter >= FILL_DEPTH) ? FILL_DEPTH : pcsrc_counter + 3'd1;
            end
         end
         FLUSH: begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (mem_wait) begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
            end else if (flush_cnt == 3'd0) begin
               state_nxt = RUN;
            end else begin
               flush_cnt_nxt = flush_cnt - 3'd1;
            end
         end
         HOLD: begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            state_nxt  = mem_wait ? HOLD : RUN;
         end
         default: state_nxt = RUN;
      endcase
   end
   // state register; lu_stalled keeps a lingering load-use from bubbling twice
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= RUN;
         flush_cnt     <= 3'd0;
         pcsrc_counter <= 3'd0;
         lu_stalled    <= 1'b0;
      end else begin
         state         <= state_nxt;
         flush_cnt     <= flush_cnt_nxt;
         pcsrc_counter <= cnt_nxt;
         lu_stalled    <= stall_now;
      end
   end
`ifdef HAZARD_PERF_CNT_EN
   // free-running event counters, wrap naturally at 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= 32'd0;
         flush_count <= 32'd0;
      end else begin
         stall_count <= stall_count + {31'd0, stall_now};
         flush_count <= flush_count + {31'd0, flush_take};
      end
   end
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed plus random stimulus against a behavioural model of the hazard sequencer
module tb_hazard_control_unit;
   localparam int FILL = 4;
   localparam int FLUSHN = 2;
   localparam int M_RUN = 0, M_FLUSH = 1, M_HOLD = 2;
   logic       clk = 1'b0;
   logic       rst, idex_memread, ifid_uses_rs2, mispredict, mem_wait;
   logic [4:0] idex_rd, ifid_rs1, ifid_rs2;
   logic       pc_write, ifid_write, ifid_flush, idex_bubble, busy;
   logic [2:0] pcsrc_counter;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_count, flush_count;
`endif
   int vectors = 0, miscompares = 0;
   int m_mode = M_RUN, m_left = 0, m_fill = 0;
   bit m_prev = 1'b0;
   int unsigned m_stalls = 0, m_flushes = 0;
   always #5 clk = ~clk;
   hazard_control_unit dut (
      .clk(clk), .rst(rst), .idex_memread(idex_memread), .idex_rd(idex_rd),
      .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
      .mispredict(mispredict), .mem_wait(mem_wait), .pc_write(pc_write),
      .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
      .pcsrc_counter(pcsrc_counter), .busy(busy)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_count(stall_count), .flush_count(flush_count)
`endif
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic drive(input bit r, input bit mr, input int rd, input int r1, input int r2,
                        input bit u2, input bit mp, input bit mw);
      rst = r; idex_memread = mr; idex_rd = 5'(rd); ifid_rs1 = 5'(r1); ifid_rs2 = 5'(r2);
      ifid_uses_rs2 = u2; mispredict = mp; mem_wait = mw;
   endtask
   task automatic cycle(input string tag);
      bit lu, epw, eiw, efl, ebb, stall;
      @(negedge clk);
      lu = idex_memread && idex_rd != 0 && (idex_rd == ifid_rs1 || (ifid_uses_rs2 && idex_rd == ifid_rs2));
      stall = 1'b0;
      epw = 1; eiw = 1; efl = 0; ebb = 0;
      if (m_mode == M_HOLD) begin
         epw = 0; eiw = 0;
      end else if (m_mode == M_FLUSH) begin
         efl = 1; ebb = 1; epw = !mem_wait; eiw = !mem_wait;
      end else if (mem_wait) begin
         epw = 0; eiw = 0;
      end else if (mispredict) begin
         efl = 1; ebb = 1;
      end else if (lu && !m_prev) begin
         stall = 1; epw = 0; eiw = 0; ebb = 1;
      end
      check(tag, {24'd0, epw, eiw, efl, ebb, m_mode != M_RUN, 3'(m_fill)},
            {24'd0, pc_write, ifid_write, ifid_flush, idex_bubble, busy, pcsrc_counter});
`ifdef HAZARD_PERF_CNT_EN
      check({tag, "_stalls"}, stall_count, m_stalls);
      check({tag, "_flushes"}, flush_count, m_flushes);
`endif
      if (rst) begin
         m_mode = M_RUN; m_left = 0; m_fill = 0; m_prev = 0; m_stalls = 0; m_flushes = 0;
      end else begin
         m_prev = stall;
         if (stall) m_stalls++;
         case (m_mode)
            M_HOLD: if (!mem_wait) m_mode = M_RUN;
            M_FLUSH: if (!mem_wait) begin
               m_left--;
               if (m_left == 0) m_mode = M_RUN;
            end
            default: if (mem_wait) m_mode = M_HOLD;
               else if (mispredict) begin
                  m_mode = M_FLUSH; m_left = FLUSHN; m_fill = 0; m_flushes++;
               end else if (!stall) m_fill = (m_fill + 1 > FILL) ? FILL : m_fill + 1;
         endcase
      end
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0);
         cycle(tag);
      end
   endtask
   initial begin
      bit mw;
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      cycle("reset");
      cycle("reset");
      idle("fill", 6);
      drive(0, 1, 5, 5, 0, 0, 0, 0); cycle("loaduse");
      idle("after_lu", 1);
      drive(0, 1, 5, 5, 0, 0, 0, 0); cycle("lu_held");
      drive(0, 1, 5, 5, 0, 0, 0, 0); cycle("lu_held2");
      drive(0, 1, 7, 3, 7, 1, 0, 0); cycle("lu_rs2");
      drive(0, 1, 7, 3, 7, 0, 0, 0); cycle("no_rs2_use");
      drive(0, 1, 0, 0, 0, 0, 0, 0); cycle("rd_zero");
      idle("refill", 4);
      drive(0, 0, 0, 0, 0, 0, 1, 0); cycle("mispredict");
      idle("flush", 5);
      drive(0, 1, 5, 5, 0, 0, 1, 0); cycle("mp_and_lu");
      drive(0, 0, 0, 0, 0, 0, 1, 0); cycle("mp_in_flush");
      idle("flush2", 4);
      for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, 0, 0, 1); cycle("memwait"); end
      idle("after_hold", 3);
      drive(0, 0, 0, 0, 0, 0, 1, 0); cycle("mp_then_wait");
      for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, 0, 0, 1); cycle("wait_in_flush"); end
      idle("flush_ext", 4);
      drive(0, 0, 0, 0, 0, 0, 1, 0); cycle("mp_then_rst");
      drive(1, 0, 0, 0, 0, 0, 0, 0); cycle("rst_in_flush");
      idle("post_rst", 2);
      drive(0, 0, 0, 0, 0, 0, 0, 1); cycle("hold_then_rst");
      drive(1, 0, 0, 0, 0, 0, 0, 1); cycle("rst_in_hold");
      idle("post_rst2", 2);
      mw = 0;
      for (int i = 0; i < 3000; i++) begin
         mw = (mw && $urandom_range(2) != 0) || $urandom_range(11) == 0;
         drive($urandom_range(149) == 0, 1'($urandom_range(1)), $urandom_range(3), $urandom_range(3),
               $urandom_range(3), 1'($urandom_range(1)), $urandom_range(9) == 0, mw);
         cycle("random");
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
